// File: rtl/inst_prefetch_buf.sv
// Instruction prefetch queue: streams sequential ROM words into a small FIFO for the fetch stage.
// Optional statistics counters are enabled with the PREFETCH_STATS_EN macro.
module inst_prefetch_buf #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h00000000
) (
  input  logic                    clk,
  input  logic                    rst,
  output logic                    rom_ce,
  output logic [31:0]             rom_addr,
  input  logic [31:0]             rom_inst,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [31:0]             out_pc,
  output logic [31:0]             out_inst,
  input  logic                    redirect,
  input  logic [31:0]             redirect_pc,
  output logic [$clog2(DEPTH):0]  count
`ifdef PREFETCH_STATS_EN
  ,
  output logic [31:0]             stall_cnt,
  output logic [31:0]             redirect_cnt
`endif
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  typedef enum logic [0:0] {
    ST_BOOT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t          state_r;
  logic [31:0]     fetch_pc_r;
  logic [PW-1:0]   head_r;
  logic [PW-1:0]   tail_r;
  logic [CW-1:0]   count_r;
  logic            valid_r;
  logic [31:0]     out_pc_r;
  logic [31:0]     out_inst_r;
  logic [31:0]     entry_pc_r   [DEPTH];
  logic [31:0]     entry_inst_r [DEPTH];

  logic            rom_ce_s;
  logic            push_s;
  logic            pop_s;
  logic [PW-1:0]   head_n_s;
  logic [PW-1:0]   tail_n_s;
  logic [CW-1:0]   count_n_s;
  logic [31:0]     fetch_pc_n_s;
  logic [31:0]     head_pc_n_s;
  logic [31:0]     head_inst_n_s;

  // Fetch issue depends only on registered occupancy and redirect, never on out_ready.
  assign rom_ce_s = (state_r == ST_RUN) && (count_r < FULL_CNT) && !redirect;
  assign push_s   = rom_ce_s;
  assign pop_s    = valid_r && out_ready && !redirect;

  assign rom_ce    = rom_ce_s;
  assign rom_addr  = fetch_pc_r;
  assign out_valid = valid_r;
  assign out_pc    = out_pc_r;
  assign out_inst  = out_inst_r;
  assign count     = count_r;

  // Next pointer, occupancy and fetch address; redirect flushes and suppresses push/pop.
  always_comb begin
    head_n_s     = head_r;
    tail_n_s     = tail_r;
    count_n_s    = count_r;
    fetch_pc_n_s = fetch_pc_r;
    if (redirect) begin
      head_n_s     = tail_r;
      tail_n_s     = tail_r;
      count_n_s    = '0;
      fetch_pc_n_s = redirect_pc & 32'hFFFF_FFFC;
    end else begin
      if (push_s) begin
        tail_n_s     = tail_r + PW'(1);
        fetch_pc_n_s = fetch_pc_r + 32'd4;
      end else begin
        tail_n_s     = tail_r;
        fetch_pc_n_s = fetch_pc_r;
      end
      if (pop_s) begin
        head_n_s = head_r + PW'(1);
      end else begin
        head_n_s = head_r;
      end
      case ({push_s, pop_s})
        2'b10:   count_n_s = count_r + CW'(1);
        2'b01:   count_n_s = count_r - CW'(1);
        default: count_n_s = count_r;
      endcase
    end
  end

  // Head entry for the next cycle, bypassing the slot being written when it becomes the head.
  always_comb begin
    head_pc_n_s   = 32'd0;
    head_inst_n_s = 32'd0;
    if (count_n_s != '0) begin
      if (push_s && (head_n_s == tail_r)) begin
        head_pc_n_s   = fetch_pc_r;
        head_inst_n_s = rom_inst;
      end else begin
        head_pc_n_s   = entry_pc_r[head_n_s];
        head_inst_n_s = entry_inst_r[head_n_s];
      end
    end else begin
      head_pc_n_s   = 32'd0;
      head_inst_n_s = 32'd0;
    end
  end

  // Control state, pointers and registered output stage.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r    <= ST_BOOT;
      fetch_pc_r <= RESET_PC;
      head_r     <= '0;
      tail_r     <= '0;
      count_r    <= '0;
      valid_r    <= 1'b0;
      out_pc_r   <= 32'd0;
      out_inst_r <= 32'd0;
    end else begin
      case (state_r)
        ST_BOOT: state_r <= ST_RUN;
        ST_RUN:  state_r <= ST_RUN;
        default: state_r <= ST_BOOT;
      endcase
      fetch_pc_r <= fetch_pc_n_s;
      head_r     <= head_n_s;
      tail_r     <= tail_n_s;
      count_r    <= count_n_s;
      valid_r    <= (count_n_s != '0);
      out_pc_r   <= head_pc_n_s;
      out_inst_r <= head_inst_n_s;
    end
  end

  // FIFO storage, written at the tail on every fetch.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        entry_pc_r[i]   <= 32'd0;
        entry_inst_r[i] <= 32'd0;
      end
    end else if (push_s) begin
      entry_pc_r[tail_r]   <= fetch_pc_r;
      entry_inst_r[tail_r] <= rom_inst;
    end
  end

`ifdef PREFETCH_STATS_EN
  logic [31:0] stall_cnt_r;
  logic [31:0] redirect_cnt_r;

  assign stall_cnt    = stall_cnt_r;
  assign redirect_cnt = redirect_cnt_r;

  // Saturating counters of consumer stalls and accepted redirects.
  always_ff @(posedge clk) begin
    if (!rst) begin
      stall_cnt_r    <= 32'd0;
      redirect_cnt_r <= 32'd0;
    end else begin
      if (out_ready && !valid_r && (state_r == ST_RUN) && (stall_cnt_r != 32'hFFFF_FFFF)) begin
        stall_cnt_r <= stall_cnt_r + 32'd1;
      end
      if (redirect && (redirect_cnt_r != 32'hFFFF_FFFF)) begin
        redirect_cnt_r <= redirect_cnt_r + 32'd1;
      end
    end
  end
`endif

endmodule
